// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
// Time-slices one 16-digit hex display between four 64-bit sources.
// In auto mode every valid source is shown for DWELL_CYCLES cycles in
// round-robin order. An advance pulse steps to the next source early.
// A request/grant lock gives one source the display until it lets go.
// disp_data is registered so it can feed the asynchronous data input of
// the display driver without glitches.
//
// Lock handshake (src_req / src_gnt):
//   - A source raises src_req[i] and keeps it high until it no longer
//     needs the display. It must not drop src_req[i] before src_gnt[i]
//     has been seen.
//   - src_gnt is registered. It goes high the cycle after src_req is
//     first sampled, is one-hot, and stays high while src_req[i] stays high.
//   - When several sources request in the same cycle, the lowest index
//     wins. Other requests wait until the holder releases.
//   - On release, waiting requests are re-evaluated in the same cycle.
//     The grant moves straight to the lowest waiting index, with no cycle
//     where src_gnt is all zero.
//   - A request beats an advance pulse in the same cycle. That advance
//     is dropped.

module hex_display_scheduler #(
  parameter int          DWELL_CYCLES = 27000000,
  parameter logic [63:0] IDLE_PATTERN = 64'h0000_0000_0000_0000
) (
  input  logic         clock_27mhz,
  input  logic         reset,
  input  logic [255:0] src_data,
  input  logic [3:0]   src_valid,
  input  logic [3:0]   src_req,
  output logic [3:0]   src_gnt,
  input  logic         advance,
  input  logic         freeze,
  output logic [63:0]  disp_data,
  output logic [1:0]   cur_src,
  output logic         locked
);

  // The dwell counter only needs to reach DWELL_CYCLES-1.
  // It never counts past that value.
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [1:0]      cur_n;
  logic [3:0]      gnt_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;

  // Decision helpers shared by the next-state logic.
  logic [1:0]      nv_idx;
  logic [1:0]      req_idx;
  logic [3:0]      req_onehot;
  logic            any_req;
  logic            any_valid;
  logic            dwell_done;
  logic            cur_dropped;
  logic [63:0]     sel_word;
  logic [63:0]     show_word;

  // Next valid source after k in round-robin order: k+1, k+2, k+3, then k.
  // If nothing else is valid, k is returned, so a lone source reselects
  // itself.
  function automatic logic [1:0] next_valid(input logic [1:0] k,
                                            input logic [3:0] v);
    logic [1:0] j;
    next_valid = k;
    // Walk from the farthest offset to the nearest.
    // The nearest valid source is written last, so it wins.
    for (int s = 3; s >= 1; s--) begin
      j = k + 2'(s);
      if (v[j]) next_valid = j;
    end
  endfunction

  // Index of the lowest set bit. The result is 0 when r is all zero;
  // callers qualify it with |r.
  function automatic logic [1:0] lowest_idx(input logic [3:0] r);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) lowest_idx = 2'(i);
    end
  endfunction

  // Combinational helpers derived from the current inputs and state.
  always_comb begin
    nv_idx      = next_valid(cur_src, src_valid);
    req_idx     = lowest_idx(src_req);
    req_onehot  = 4'b0001 << req_idx;
    any_req     = |src_req;
    any_valid   = |src_valid;
    dwell_done  = (cnt == CNT_LAST);
    cur_dropped = ~src_valid[cur_src];
    sel_word    = src_data[{cur_src, 6'd0} +: 64];
  end

  // Next-state, next-source, next-counter and next-grant selection.
  always_comb begin
    state_n = state;
    cur_n   = cur_src;
    cnt_n   = cnt;
    gnt_n   = src_gnt;

    case (state)
      IDLE: begin
        cnt_n = '0;
        gnt_n = 4'b0000;
        if (any_req) begin
          state_n = LOCKED;
          cur_n   = req_idx;
          gnt_n   = req_onehot;
        end else if (any_valid) begin
          state_n = ROTATE;
          cur_n   = nv_idx;
        end
      end

      ROTATE: begin
        gnt_n = 4'b0000;
        if (any_req) begin
          // A lock request beats everything, including a pending advance.
          state_n = LOCKED;
          cur_n   = req_idx;
          gnt_n   = req_onehot;
          cnt_n   = '0;
        end else if (!any_valid) begin
          // cur_src is kept so the next wake-up continues round-robin
          // from this source.
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cur_dropped || advance || dwell_done) begin
          // One step even if advance and dwell expiry fall in the same
          // cycle.
          cur_n = nv_idx;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      LOCKED: begin
        // While locked, cur_src always equals the granted index.
        cnt_n = '0;
        if (!src_req[cur_src]) begin
          if (any_req) begin
            // Hand the lock straight to the lowest waiting requester.
            cur_n = req_idx;
            gnt_n = req_onehot;
          end else if (any_valid) begin
            state_n = ROTATE;
            cur_n   = nv_idx;
            gnt_n   = 4'b0000;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end
      end

      default: begin
        state_n = IDLE;
        cur_n   = 2'd0;
        cnt_n   = '0;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  // State, source, counter and grant registers. Reset wins over all
  // inputs.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state   <= IDLE;
      cur_src <= 2'd0;
      cnt     <= '0;
      src_gnt <= 4'b0000;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      cur_src <= cur_n;
      cnt     <= cnt_n;
      src_gnt <= gnt_n;
      locked  <= |gnt_n;
    end
  end

  // Word for the current selection. IDLE shows the idle pattern.
  // Every other state shows the selected source, valid or not.
  always_comb begin
    show_word = sel_word;
    if (state == IDLE) show_word = IDLE_PATTERN;
  end

  // Display register: one cycle behind the selection.
  // It holds its value while freeze is high.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      disp_data <= IDLE_PATTERN;
    end else if (!freeze) begin
      disp_data <= show_word;
    end
  end

`ifndef SYNTHESIS
  // Structural invariants of the grant and dwell logic.
  a_gnt_onehot0: assert property (@(posedge clock_27mhz) disable iff (reset)
    $onehot0(src_gnt));
  a_locked_gnt: assert property (@(posedge clock_27mhz) disable iff (reset)
    locked == (|src_gnt));
  a_cnt_range: assert property (@(posedge clock_27mhz) disable iff (reset)
    cnt <= CNT_LAST);
`endif

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Testbench for hex_display_scheduler (DWELL_CYCLES = 8).
// A table of per-cycle vectors holds the driven inputs and the outputs
// expected right after that clock edge. The driver pushes each
// expectation onto a queue when it drives the inputs. The checker pops
// the queue once the DUT has clocked and compares. A hand-written
// sequence at the end covers reset in the middle of a lock.

module tb_hex_display_scheduler;

  localparam int          DWELL = 8;
  localparam logic [63:0] IP = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D3 = 64'h4444_4444_4444_4444;

  // Expected word packing: {disp_data, cur_src, src_gnt, locked}.
  localparam int W = 71;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] src_data = {D3, D2, D1, D0};
  logic [3:0]   src_valid = 4'b0000;
  logic [3:0]   src_req = 4'b0000;
  logic         advance = 1'b0;
  logic         freeze = 1'b0;
  logic [3:0]   src_gnt;
  logic [63:0]  disp_data;
  logic [1:0]   cur_src;
  logic         locked;

  always #5 clk = ~clk;

  hex_display_scheduler #(
    .DWELL_CYCLES(DWELL),
    .IDLE_PATTERN(IP)
  ) dut (
    .clock_27mhz(clk),
    .reset(reset),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_req(src_req),
    .src_gnt(src_gnt),
    .advance(advance),
    .freeze(freeze),
    .disp_data(disp_data),
    .cur_src(cur_src),
    .locked(locked)
  );

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  req;
    logic        adv;
    logic        frz;
    logic [63:0] disp;
    logic [1:0]  cur;
    logic [3:0]  gnt;
    logic        lk;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad = 0;

  function automatic vec_t mk(string n, logic r, logic [3:0] v, logic [3:0] q,
                              logic a, logic f, logic [63:0] d, logic [1:0] c,
                              logic [3:0] g, logic l);
    vec_t x;
    x.name = n; x.rst = r; x.valid = v; x.req = q; x.adv = a; x.frz = f;
    x.disp = d; x.cur = c; x.gnt = g; x.lk = l;
    return x;
  endfunction

  // Driver: applies one vector on the falling edge and records its
  // expectation.
  task automatic drive(input vec_t v);
    @(negedge clk);
    reset     = v.rst;
    src_valid = v.valid;
    src_req   = v.req;
    advance   = v.adv;
    freeze    = v.frz;
    exp_q.push_back({v.disp, v.cur, v.gnt, v.lk});
    name_q.push_back(v.name);
  endtask

  // Checker: after the rising edge, pops one expectation and compares it
  // with the DUT outputs.
  task automatic check();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        n;
    @(posedge clk);
    #1;
    got = {disp_data, cur_src, src_gnt, locked};
    exp = exp_q.pop_front();
    n   = name_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got disp=%h cur=%0d gnt=%b lk=%b, want disp=%h cur=%0d gnt=%b lk=%b",
               n, got[70:7], got[6:5], got[4:1], got[0],
               exp[70:7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic run_one(input vec_t v);
    drive(v);
    check();
  endtask

  initial begin
    logic [1:0]  c;
    logic [63:0] d;

    // ---- reset / idle ----
    vecs.push_back(mk("reset", 1, 4'b0000, 4'b0000, 0, 0, IP, 0, 4'b0000, 0));
    vecs.push_back(mk("reset", 1, 4'b0000, 4'b0000, 0, 0, IP, 0, 4'b0000, 0));
    for (int k = 0; k < 20; k++)
      vecs.push_back(mk("idle_hold", 0, 4'b0000, 4'b0000, 0, 0, IP, 0, 4'b0000, 0));

    // ---- auto rotation over sources 1,3,0 then 1 (8 cycles each) ----
    for (int k = 0; k < 25; k++) begin
      c = (k < 8) ? 2'd1 : (k < 16) ? 2'd3 : (k < 24) ? 2'd0 : 2'd1;
      d = (k == 0) ? IP : (k <= 8) ? D1 : (k <= 16) ? D3 : D0;
      vecs.push_back(mk("rotate", 0, 4'b1011, 4'b0000, 0, 0, d, c, 4'b0000, 0));
    end

    // ---- advance early in a dwell, then advance on the expiry cycle ----
    vecs.push_back(mk("dwell_a", 0, 4'b1011, 4'b0000, 0, 0, D1, 1, 4'b0000, 0));
    vecs.push_back(mk("dwell_b", 0, 4'b1011, 4'b0000, 0, 0, D1, 1, 4'b0000, 0));
    vecs.push_back(mk("adv_step", 0, 4'b1011, 4'b0000, 1, 0, D1, 3, 4'b0000, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk("adv_cnt_clr", 0, 4'b1011, 4'b0000, 0, 0, D3, 3, 4'b0000, 0));
    vecs.push_back(mk("adv_next", 0, 4'b1011, 4'b0000, 0, 0, D3, 0, 4'b0000, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk("dwell_src0", 0, 4'b1011, 4'b0000, 0, 0, D0, 0, 4'b0000, 0));
    vecs.push_back(mk("adv_expire", 0, 4'b1011, 4'b0000, 1, 0, D0, 1, 4'b0000, 0));
    vecs.push_back(mk("single_step", 0, 4'b1011, 4'b0000, 0, 0, D1, 1, 4'b0000, 0));

    // ---- drop-out of the shown source, single source, all gone ----
    vecs.push_back(mk("drop_cur", 0, 4'b1001, 4'b0000, 0, 0, D1, 3, 4'b0000, 0));
    vecs.push_back(mk("drop_next", 0, 4'b1001, 4'b0000, 0, 0, D3, 3, 4'b0000, 0));
    vecs.push_back(mk("one_valid", 0, 4'b1000, 4'b0000, 1, 0, D3, 3, 4'b0000, 0));
    vecs.push_back(mk("all_gone", 0, 4'b0000, 4'b0000, 0, 0, D3, 3, 4'b0000, 0));
    vecs.push_back(mk("idle_again", 0, 4'b0000, 4'b0000, 0, 0, IP, 3, 4'b0000, 0));
    vecs.push_back(mk("wake", 0, 4'b1011, 4'b0000, 0, 0, IP, 0, 4'b0000, 0));
    vecs.push_back(mk("wake_show", 0, 4'b1011, 4'b0000, 0, 0, D0, 0, 4'b0000, 0));

    // ---- lock arbitration and handoff ----
    vecs.push_back(mk("lock_req", 0, 4'b1011, 4'b0110, 0, 0, D0, 1, 4'b0010, 1));
    vecs.push_back(mk("lock_adv", 0, 4'b1011, 4'b0110, 1, 0, D1, 1, 4'b0010, 1));
    vecs.push_back(mk("lock_novalid", 0, 4'b1001, 4'b0110, 0, 0, D1, 1, 4'b0010, 1));
    vecs.push_back(mk("lock_handoff", 0, 4'b1001, 4'b0100, 0, 0, D1, 2, 4'b0100, 1));
    vecs.push_back(mk("lock_src2", 0, 4'b1001, 4'b0100, 0, 0, D2, 2, 4'b0100, 1));
    vecs.push_back(mk("release", 0, 4'b1001, 4'b0000, 0, 0, D2, 3, 4'b0000, 0));
    vecs.push_back(mk("post_release", 0, 4'b1011, 4'b0000, 0, 0, D3, 3, 4'b0000, 0));

    // ---- freeze for 20 cycles while rotation continues ----
    for (int k = 1; k <= 20; k++) begin
      c = (k <= 6) ? 2'd3 : (k <= 14) ? 2'd0 : 2'd1;
      vecs.push_back(mk("freeze", 0, 4'b1011, 4'b0000, 0, 1, D3, c, 4'b0000, 0));
    end
    vecs.push_back(mk("unfreeze", 0, 4'b1011, 4'b0000, 0, 0, D1, 1, 4'b0000, 0));

    // ---- apply the table ----
    for (int i = 0; i < vecs.size(); i++) run_one(vecs[i]);

    // ---- hand-written: reset in the middle of a lock held by source 3 ----
    run_one(mk("req_beats_adv", 0, 4'b1011, 4'b1000, 1, 0, D1, 3, 4'b1000, 1));
    run_one(mk("lock3_hold", 0, 4'b1011, 4'b1000, 0, 0, D3, 3, 4'b1000, 1));
    run_one(mk("reset_midlock", 1, 4'b1011, 4'b1000, 0, 0, IP, 0, 4'b0000, 0));
    run_one(mk("regrant", 0, 4'b1011, 4'b1000, 0, 0, IP, 3, 4'b1000, 1));
    run_one(mk("regrant_show", 0, 4'b1011, 4'b1000, 0, 0, D3, 3, 4'b1000, 1));
    run_one(mk("rel_to_rotate", 0, 4'b1011, 4'b0000, 0, 0, D3, 0, 4'b0000, 0));
    run_one(mk("rotate_show", 0, 4'b1011, 4'b0000, 0, 0, D0, 0, 4'b0000, 0));

    // Every expectation pushed must have been consumed.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
Shares the single 16-digit hex dot-matrix display between four requesters, e.g. FSM debug state, sensor readings and position data. It time-slices the 64-bit display word round-robin among valid sources and supports a manual-advance button. A request/grant lock lets one source hold the display exclusively. Its registered 64-bit output feeds the display driver's asynchronous data input.

Parameters:
DWELL_CYCLES, 27000000, clock_27mhz cycles each source is shown in auto mode (1 s); sim uses 8.
IDLE_PATTERN, 64'h0000_0000_0000_0000, word shown when no source is valid.

Ports:
clock_27mhz  input  1  system clock
reset  input  1  synchronous, active-high reset
src_data  input  256  four 64-bit words; source i at [64*i+63:64*i]
src_valid  input  4  source i has displayable data
src_req  input  4  source i requests exclusive lock
src_gnt  output  4  one-hot lock grant; all zero when unlocked
advance  input  1  single-cycle pulse (debounced upstream), step to next source
freeze  input  1  hold disp_data at current value
disp_data  output  64  word to display driver
cur_src  output  2  index of source currently shown
locked  output  1  high while any grant is active

Behaviour:
- Everything is synchronous to clock_27mhz. Reset is synchronous, active-high, and wins over all inputs.
- Reset values: state IDLE, disp_data=IDLE_PATTERN, cur_src=0, src_gnt=0, locked=0, dwell counter=0.
- next_valid(k): first index j in (k+1, k+2, k+3, k) mod 4 with src_valid[j]=1. It wraps 3->0 and can return k itself.
- States:
  - IDLE: shows IDLE_PATTERN.
    - Any src_req -> LOCKED.
    - Otherwise, any src_valid -> ROTATE with cur_src=next_valid(cur_src) and counter=0.
  - ROTATE: shows src_data[cur_src] and increments the counter each cycle.
    - Priority 1: any src_req -> LOCKED, granting the lowest requesting index.
    - Priority 2: no src_valid -> IDLE.
    - Priority 3: src_valid[cur_src]=0 -> cur_src=next_valid(cur_src), counter=0.
    - Priority 4: advance=1 or counter==DWELL_CYCLES-1 -> cur_src=next_valid(cur_src), counter=0. Both in the same cycle produce a single step.
    - With one valid source, a step reselects the same source and the counter clears.
  - LOCKED: src_gnt is one-hot at index g, cur_src=g, locked=1, shows src_data[g] regardless of src_valid[g].
    - advance is ignored; the counter is held at 0.
    - On src_req[g]=0: src_gnt clears the next cycle, then go to ROTATE with cur_src=next_valid(g), or to IDLE if none is valid.
    - Requests from other sources while locked are not serviced until release. They are re-evaluated in the release cycle, so the lowest pending index is granted directly (LOCKED->LOCKED) and src_gnt switches one-hot without an all-zero cycle.
- Grant rules:
  - src_gnt is registered and asserted the cycle after src_req is first sampled.
  - The grant is held as long as the requester holds req; requesters must not drop req before gnt.
  - Simultaneous requests: the lowest index wins.
  - req together with advance in the same cycle: req wins and advance is dropped.
- disp_data is registered; it equals the selected word one cycle after the selection or source data changes, so latency is 1 cycle.
- While freeze=1:
  - disp_data holds its value; the state, counter, cur_src and grants keep updating.
  - On release, disp_data resumes on the next cycle.
- Reset in any state, including mid-lock, returns to the reset values at the next edge; src_gnt drops to 0.
- The counter is wide enough for DWELL_CYCLES-1 (min 25 bits at the default) and never wraps past DWELL_CYCLES-1.

Test Plan:
- Reset/idle: assert reset for 2 cycles with src_valid=0 -> disp_data=IDLE_PATTERN, cur_src=0, src_gnt=0, locked=0; the state stays IDLE for 20 cycles.
- Rotation (DWELL_CYCLES=8): src_valid=4'b1011 with source i data=64'h1111_1111_1111_1111*(i+1) -> cur_src steps 1,3,0,1 every 8 cycles, and disp_data follows 1 cycle after each cur_src change.
- Advance and drop-out: pulse advance at cycle 3 of a dwell -> immediate step with the counter cleared. Then deassert src_valid[cur_src] -> step to the next valid source the next cycle. Clear all valid -> IDLE_PATTERN.
- Lock arbitration: src_req=4'b0110 in ROTATE -> src_gnt=4'b0010 one cycle later and cur_src=1. An advance pulse has no effect. Drop req[1] -> src_gnt=4'b0100 with no zero cycle. Drop req[2] -> src_gnt=0 and return to ROTATE at next_valid(2).
- Freeze: freeze=1 during rotation for 20 cycles -> disp_data constant while cur_src advances. freeze=0 -> disp_data=src_data[cur_src] the next cycle.
- Reset mid-lock: reset while src_gnt=4'b1000 -> all outputs take their reset values at the next edge; with src_req still high after reset, grant re-asserts one cycle after reset deasserts.
